conv_feeder: RTL and testbench

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 193 +++++++++++++++++++
 tb/tb_conv_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_feeder
// Purpose  : Sequences one convolution job into a conv unit. It loads
//            KERNEL_NUM weight words, then one bias word, then pix_num pixels,
//            and raises conv_valid on the cycles where the conv unit output
//            holds a complete kernel result.
// Options  : CONV_FEEDER_WEIGHT_REUSE_EN adds the reuse_w input. When reuse_w
//            is 1 the job keeps the loaded weights and bias and streams
//            pixels only.
// Revision : 1.0 - initial release
// ============================================================================
module conv_feeder #(
  parameter int KERNEL_NUM = 25,
  parameter int DW         = 16,
  parameter int CONV_LAT   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   pix_num,
`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
  input  logic          reuse_w,
`endif
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] conv_in,
  output logic          w_valid,
  output logic          b_valid,
  output logic          i_valid,
  output logic          conv_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                state_q;
  logic [15:0]           pix_num_q;
  logic [15:0]           w_cnt_q;
  logic [15:0]           pix_cnt_q;
  logic [7:0]            drain_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DW-1:0]         conv_in_q;
  logic                  w_valid_q;
  logic                  b_valid_q;
  logic                  i_valid_q;
  logic                  tag_q;
  logic [CONV_LAT-1:0]   sr_q;
  logic                  beat;
  logic                  reuse_sel;

`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
  assign reuse_sel = reuse_w;
`else
  assign reuse_sel = 1'b0;
`endif

  // Source is accepted only while a load or stream phase is active.
  always_comb begin
    s_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B) ||
              (state_q == ST_STREAM);
  end

  assign beat = s_valid && s_ready;

  // Job sequencing: phase transitions, beat counters, busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pix_num_q   <= 16'd0;
      w_cnt_q     <= 16'd0;
      pix_cnt_q   <= 16'd0;
      drain_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pix_num_q   <= pix_num;
            w_cnt_q     <= 16'd0;
            pix_cnt_q   <= 16'd0;
            drain_cnt_q <= 8'd0;
            busy_q      <= 1'b1;
            if (reuse_sel) begin
              state_q <= (pix_num == 16'd0) ? ST_DRAIN : ST_STREAM;
            end else begin
              state_q <= ST_LOAD_W;
            end
          end
        end
        ST_LOAD_W: begin
          if (beat) begin
            if (w_cnt_q == 16'(KERNEL_NUM - 1)) begin
              w_cnt_q <= 16'd0;
              state_q <= ST_LOAD_B;
            end else begin
              w_cnt_q <= w_cnt_q + 16'd1;
            end
          end
        end
        ST_LOAD_B: begin
          if (beat) begin
            state_q <= (pix_num_q == 16'd0) ? ST_DRAIN : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat) begin
            if (pix_cnt_q == pix_num_q - 16'd1) begin
              pix_cnt_q <= 16'd0;
              state_q   <= ST_DRAIN;
            end else begin
              pix_cnt_q <= pix_cnt_q + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          // The first DRAIN cycle is the last i_valid cycle, so waiting
          // CONV_LAT further cycles lets the final conv_valid land before done.
          if (drain_cnt_q == 8'(CONV_LAT)) begin
            drain_cnt_q <= 8'd0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Register the accepted word and its qualifier; pixel beats that complete
  // a kernel window are tagged for conv_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_in_q <= '0;
      w_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      i_valid_q <= 1'b0;
      tag_q     <= 1'b0;
    end else begin
      if (beat) begin
        conv_in_q <= s_data;
      end
      w_valid_q <= beat && (state_q == ST_LOAD_W);
      b_valid_q <= beat && (state_q == ST_LOAD_B);
      i_valid_q <= beat && (state_q == ST_STREAM);
      tag_q     <= beat && (state_q == ST_STREAM) &&
                   (pix_cnt_q >= 16'(KERNEL_NUM - 1));
    end
  end

  // Delay the window tag by the conv unit latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= tag_q;
      for (int k = 1; k < CONV_LAT; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign conv_in    = conv_in_q;
  assign w_valid    = w_valid_q;
  assign b_valid    = b_valid_q;
  assign i_valid    = i_valid_q;
  assign conv_valid = sr_q[CONV_LAT-1];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_feeder.sv
`default_nettype none
// Testbench for conv_feeder: directed jobs with a scoreboard of expected
// qualifier/data beats and expected conv_valid cycles.
module tb_conv_feeder;

  localparam int KN  = 25;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic [15:0]   pix_num = 16'd0;
  logic [DW-1:0] s_data  = '0;
  logic          s_valid = 1'b0;
`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
  logic          reuse_w = 1'b0;
`endif
  logic          s_ready;
  logic [DW-1:0] conv_in;
  logic          w_valid;
  logic          b_valid;
  logic          i_valid;
  logic          conv_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  conv_feeder #(
    .KERNEL_NUM (KN),
    .DW         (DW),
    .CONV_LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_num    (pix_num),
`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
    .reuse_w    (reuse_w),
`endif
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .conv_in    (conv_in),
    .w_valid    (w_valid),
    .b_valid    (b_valid),
    .i_valid    (i_valid),
    .conv_valid (conv_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [1:0]    kind;   // 0 weight, 1 bias, 2 pixel
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cv_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nw = 0, nb = 0, ni = 0, ncv = 0, ndone = 0;
  int   done_cyc = 0, last_q_cyc = 0, pix_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: advance past the edge, then score what the DUT produced.
  task automatic tick();
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    cyc++;
    if (w_valid || b_valid || i_valid) begin
      chk("qual_onehot", 32'($countones({w_valid, b_valid, i_valid})), 32'd1);
      last_q_cyc = cyc;
      t = exp_q.size();
      chk("beat_expected", 32'(t > 0), 32'd1);
      if (t > 0) begin
        e = exp_q.pop_front();
        chk("qual_kind", {30'd0, (i_valid ? 2'd2 : (b_valid ? 2'd1 : 2'd0))}, {30'd0, e.kind});
        chk("conv_in", 32'(conv_in), 32'(e.data));
      end
      if (w_valid) nw++;
      if (b_valid) nb++;
      if (i_valid) begin
        ni++;
        if (pix_idx >= KN - 1) cv_q.push_back(cyc + LAT);
        pix_idx++;
      end
    end
    if (conv_valid) begin
      ncv++;
      t = cv_q.size();
      chk("conv_valid_expected", 32'(t > 0), 32'd1);
      if (t > 0) chk("conv_valid_cycle", 32'(cyc), 32'(cv_q.pop_front()));
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},    32'(s_ready),    32'd0);
    chk({tag, "_conv_in"},    32'(conv_in),    32'd0);
    chk({tag, "_w_valid"},    32'(w_valid),    32'd0);
    chk({tag, "_b_valid"},    32'(b_valid),    32'd0);
    chk({tag, "_i_valid"},    32'(i_valid),    32'd0);
    chk({tag, "_conv_valid"}, 32'(conv_valid), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
  endtask

  // Runs one job. gaps inserts an idle source cycle before every word,
  // poke pulses start mid-job, abort_pix >= 0 resets once that pixel is taken.
  task automatic run_job(input string name, input int pix, input bit gaps,
                         input bit reuse, input bit poke, input int abort_pix);
    int            nw0, nb0, ni0, ncv0, nd0, nwt, total, budget, exp_cv;
    bit            acc;
    logic [DW-1:0] val;
    logic [1:0]    k;
    nw0 = nw; nb0 = nb; ni0 = ni; ncv0 = ncv; nd0 = ndone;
    pix_idx = 0;
    nwt     = reuse ? 0 : KN + 1;
    total   = nwt + pix;
    start   = 1'b1;
    pix_num = 16'(pix);
`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
    reuse_w = reuse;
`endif
    tick();
    start = 1'b0;
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int n = 0; n < total; n++) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        tick();
      end
      val     = DW'(n * 32'h1357 + 32'h00A5);
      k       = (n < nwt - 1) ? 2'd0 : ((n == nwt - 1) ? 2'd1 : 2'd2);
      s_valid = 1'b1;
      s_data  = val;
      if (poke && n == 3) begin
        start   = 1'b1;
        pix_num = 16'd5;
      end
      exp_q.push_back('{kind: k, data: val});
      budget = 0;
      do begin
        acc = s_ready;
        tick();
        start = 1'b0;
        budget++;
      end while (!acc && budget < 20);
      chk({name, "_accept_timeout"}, 32'(acc), 32'd1);
      if (abort_pix >= 0 && n == nwt + abort_pix) begin
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero({name, "_midreset"});
        exp_q.delete();
        cv_q.delete();
        #3;
        rst_n = 1'b1;
        return;
      end
    end
    s_valid = 1'b0;
    budget  = 0;
    while (ndone == nd0 && budget < 20) begin
      tick();
      budget++;
    end
    chk({name, "_done_count"}, 32'(ndone - nd0), 32'd1);
    chk({name, "_done_cycle"}, 32'(done_cyc), 32'(last_q_cyc + LAT + 1));
    tick();
    chk({name, "_done_cleared"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"},    32'(busy), 32'd0);
    exp_cv = (pix >= KN) ? pix - KN + 1 : 0;
    chk({name, "_w_count"},  32'(nw - nw0),   32'(reuse ? 0 : KN));
    chk({name, "_b_count"},  32'(nb - nb0),   32'(reuse ? 0 : 1));
    chk({name, "_i_count"},  32'(ni - ni0),   32'(pix));
    chk({name, "_cv_count"}, 32'(ncv - ncv0), 32'(exp_cv));
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_cv_left"},    32'(cv_q.size()),  32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    run_job("basic",     30, 1'b0, 1'b0, 1'b0, -1);
    run_job("gaps",      30, 1'b1, 1'b0, 1'b1, -1);
    run_job("pix0",       0, 1'b0, 1'b0, 1'b0, -1);
    run_job("pix10",     10, 1'b0, 1'b0, 1'b1, -1);
    run_job("abort",     30, 1'b0, 1'b0, 1'b0, 12);
    run_job("after_rst", 30, 1'b0, 1'b0, 1'b0, -1);
`ifdef CONV_FEEDER_WEIGHT_REUSE_EN
    run_job("reuse",     25, 1'b0, 1'b1, 1'b1, -1);
    run_job("reload",    26, 1'b1, 1'b0, 1'b0, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
